des3_job_sequencer: RTL and testbench



---
 rtl/des3_job_sequencer_if.sv | 22 ++
 rtl/des3_job_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_des3_job_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/des3_job_sequencer_if.sv
// Wishbone B3 bus between the job sequencer (master) and the des3 register slave.
interface des3_job_sequencer_if;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i
  );
endinterface

// File: rtl/des3_job_sequencer.sv
// Runs one 3DES job on the des3 slave: write key/block/ctrl, poll status, read result.
// Every transfer is one strobe cycle followed by one idle cycle; a state change takes
// one extra idle cycle, so a cache-hit job with one poll returns 15 cycles after accept.
module des3_job_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_POLLS = 256,
  parameter int unsigned KEY_CACHE = 1
) (
  input  logic          clk,
  input  logic          rst_sys,
  input  logic          job_valid,
  output logic          job_ready,
  input  logic [191:0]  job_key,
  input  logic [63:0]   job_data,
  input  logic          job_decrypt,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [63:0]   res_data,
  output logic [1:0]    res_err,
  des3_job_sequencer_if.master wbm
);

  localparam int unsigned PollW = $clog2(MAX_POLLS + 1);

  typedef enum logic [2:0] {StIdle, StWrite, StPoll, StRead, StDone} state_e;

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic               stb_q, stb_d;
  logic [PollW-1:0]   polls_q, polls_d;
  logic [191:0]       key_q, key_d;
  logic [63:0]        data_q, data_d;
  logic               dec_q, dec_d;
  logic [191:0]       cache_key_q, cache_key_d;
  logic               cache_vld_q, cache_vld_d;
  logic [63:0]        res_data_q, res_data_d;
  logic [1:0]         res_err_q, res_err_d;
  logic               ack_ok, err_hit, cache_hit;

  // err wins over ack; both are ignored while no strobe is out
  assign err_hit   = stb_q & wbm.wbm_err_i;
  assign ack_ok    = stb_q & wbm.wbm_ack_i & ~wbm.wbm_err_i;
  assign cache_hit = (KEY_CACHE != 0) && cache_vld_q && (job_key == cache_key_q);

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst_sys) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      stb_q       <= 1'b0;
      polls_q     <= '0;
      key_q       <= '0;
      data_q      <= '0;
      dec_q       <= 1'b0;
      cache_key_q <= '0;
      cache_vld_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stb_q       <= stb_d;
      polls_q     <= polls_d;
      key_q       <= key_d;
      data_q      <= data_d;
      dec_q       <= dec_d;
      cache_key_q <= cache_key_d;
      cache_vld_q <= cache_vld_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

  // Next-state: transfer completion on ack/err, next transfer or state change in idle cycle
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stb_d       = stb_q;
    polls_d     = polls_q;
    key_d       = key_q;
    data_d      = data_q;
    dec_d       = dec_q;
    cache_key_d = cache_key_q;
    cache_vld_d = cache_vld_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    unique case (state_q)
      StIdle: begin
        if (job_valid) begin
          key_d      = job_key;
          data_d     = job_data;
          dec_d      = job_decrypt;
          res_data_d = '0;
          res_err_d  = 2'b00;
          idx_d      = cache_hit ? 4'd6 : 4'd0;
          stb_d      = 1'b0;
          state_d    = StWrite;
        end
      end
      StWrite, StPoll, StRead: begin
        if (err_hit) begin
          stb_d       = 1'b0;
          res_err_d   = 2'b01;
          cache_vld_d = 1'b0;
          state_d     = StDone;
        end else if (ack_ok) begin
          stb_d = 1'b0;
          if (state_q == StWrite) begin
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd8) begin
              cache_key_d = key_q;
              cache_vld_d = 1'b1;
              polls_d     = '0;
            end
          end else if (state_q == StPoll) begin
            // idx 0: poll again, 1: status done, 2: poll budget exhausted
            if (wbm.wbm_dat_i[0]) begin
              idx_d = 4'd1;
            end else begin
              polls_d = polls_q + PollW'(1);
              idx_d   = (polls_q + PollW'(1) == PollW'(MAX_POLLS)) ? 4'd2 : 4'd0;
            end
          end else begin
            if (idx_q == 4'd0) res_data_d[63:32] = wbm.wbm_dat_i;
            else               res_data_d[31:0]  = wbm.wbm_dat_i;
            idx_d = idx_q + 4'd1;
          end
        end else if (!stb_q) begin
          if (state_q == StWrite) begin
            if (idx_q == 4'd9) begin
              state_d = StPoll;
              idx_d   = 4'd0;
            end else begin
              stb_d = 1'b1;
            end
          end else if (state_q == StPoll) begin
            if (idx_q == 4'd0) begin
              stb_d = 1'b1;
            end else if (idx_q == 4'd1) begin
              state_d = StRead;
              idx_d   = 4'd0;
            end else begin
              res_err_d = 2'b10;
              state_d   = StDone;
            end
          end else begin
            if (idx_q == 4'd2) state_d = StDone;
            else               stb_d   = 1'b1;
          end
        end
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: bus fields are decoded from stable registers and forced to zero without strobe
  always_comb begin
    job_ready     = (state_q == StIdle);
    res_valid     = (state_q == StDone);
    res_data      = res_data_q;
    res_err       = res_err_q;
    wbm.wbm_cyc_o = stb_q;
    wbm.wbm_stb_o = stb_q;
    wbm.wbm_sel_o = stb_q ? 4'hF : 4'h0;
    wbm.wbm_we_o  = stb_q && (state_q == StWrite);
    wbm.wbm_adr_o = '0;
    wbm.wbm_dat_o = '0;
    if (stb_q) begin
      if (state_q == StWrite) begin
        wbm.wbm_adr_o = BASE_ADDR + {26'b0, idx_q, 2'b00};
        if (idx_q < 4'd6)       wbm.wbm_dat_o = key_q[191 - 32 * int'(idx_q) -: 32];
        else if (idx_q == 4'd6) wbm.wbm_dat_o = data_q[63:32];
        else if (idx_q == 4'd7) wbm.wbm_dat_o = data_q[31:0];
        else                    wbm.wbm_dat_o = {30'b0, dec_q, 1'b1};
      end else if (state_q == StPoll) begin
        wbm.wbm_adr_o = BASE_ADDR + 32'h24;
      end else if (state_q == StRead) begin
        wbm.wbm_adr_o = BASE_ADDR + 32'h28 + {26'b0, idx_q, 2'b00};
      end
    end
  end

endmodule

// File: tb/tb_des3_job_sequencer.sv
// Directed bench for des3_job_sequencer with a zero-wait-state des3 slave model.
module tb_des3_job_sequencer;

  localparam logic [191:0] K1 = 192'h0123456789ABCDEF_FEDCBA9876543210_89ABCDEF01234567;
  localparam logic [191:0] K2 = 192'h0011223344556677_8899AABBCCDDEEFF_0F1E2D3C4B5A6978;
  localparam logic [63:0]  D1 = 64'h4E6F772069732074;
  localparam logic [63:0]  R1 = 64'h3FA40E8A984D4815;

  logic         clk = 1'b0;
  logic         rst_sys = 1'b1;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [191:0] job_key = '0;
  logic [63:0]  job_data = '0;
  logic         job_decrypt = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [63:0]  res_data;
  logic [1:0]   res_err;

  des3_job_sequencer_if bus ();

  des3_job_sequencer #(
    .BASE_ADDR(32'h0000_0000),
    .MAX_POLLS(4),
    .KEY_CACHE(1)
  ) dut (
    .clk        (clk),
    .rst_sys    (rst_sys),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_key    (job_key),
    .job_data   (job_data),
    .job_decrypt(job_decrypt),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_err    (res_err),
    .wbm        (bus)
  );

  always #5 clk = ~clk;

  // Slave model state
  int          status_after = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_adr = '0;
  int          poll_total = 0;
  int          poll_base = 0;
  int          n_xfer = 0;
  int          start_n = 0;
  logic [31:0] log_adr [128];
  logic        log_we  [128];
  logic [31:0] log_dat [128];
  logic        prev_done = 1'b0;
  logic        proto_bad = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  // Zero-wait slave: ack (or err) in the strobe cycle, status done after status_after polls
  always_comb begin
    bus.wbm_ack_i = 1'b0;
    bus.wbm_err_i = 1'b0;
    bus.wbm_dat_i = '0;
    if (bus.wbm_stb_o) begin
      if (err_en && bus.wbm_adr_o == err_adr) bus.wbm_err_i = 1'b1;
      else                                    bus.wbm_ack_i = 1'b1;
      if (!bus.wbm_we_o) begin
        case (bus.wbm_adr_o)
          32'h24:  bus.wbm_dat_i = ((poll_total - poll_base) >= status_after) ? 32'd1 : 32'd0;
          32'h28:  bus.wbm_dat_i = R1[63:32];
          32'h2C:  bus.wbm_dat_i = R1[31:0];
          default: bus.wbm_dat_i = '0;
        endcase
      end
    end
  end

  // Transfer log and back-to-back strobe detector
  always @(posedge clk) begin
    if (bus.wbm_stb_o && (bus.wbm_ack_i || bus.wbm_err_i)) begin
      if (n_xfer < 128) begin
        log_adr[n_xfer] <= bus.wbm_adr_o;
        log_we[n_xfer]  <= bus.wbm_we_o;
        log_dat[n_xfer] <= bus.wbm_we_o ? bus.wbm_dat_o : bus.wbm_dat_i;
      end
      n_xfer <= n_xfer + 1;
      if (!bus.wbm_we_o && bus.wbm_adr_o == 32'h24) poll_total <= poll_total + 1;
    end
    prev_done <= bus.wbm_stb_o && (bus.wbm_ack_i || bus.wbm_err_i);
    if (prev_done && (bus.wbm_stb_o || bus.wbm_cyc_o)) proto_bad <= 1'b1;
    if (bus.wbm_stb_o && bus.wbm_sel_o != 4'hF) proto_bad <= 1'b1;
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_xfer(input string tag, input int i, input logic [31:0] adr,
                            input logic we, input logic [31:0] dat);
    check_eq(tag, {log_adr[start_n + i], log_we[start_n + i], log_dat[start_n + i]},
             {adr, we, dat});
  endtask

  // Offers a job in IDLE; returns just after the accept edge
  task automatic start_job(input logic [191:0] key, input logic [63:0] data, input logic dec,
                           input int st_after);
    status_after = st_after;
    check_eq("job_ready_idle", job_ready, 1'b1);
    job_key     = key;
    job_data    = data;
    job_decrypt = dec;
    job_valid   = 1'b1;
    start_n     = n_xfer;
    poll_base   = poll_total;
    @(posedge clk);
    #1;
    job_valid = 1'b0;
    check_eq("job_ready_drop", job_ready, 1'b0);
  endtask

  task automatic wait_result(output int lat);
    lat = -1;
    for (int c = 1; c <= 400 && lat < 0; c++) begin
      @(posedge clk);
      #1;
      if (res_valid) lat = c;
    end
    check_eq("res_valid_seen", lat > 0, 1'b1);
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  logic [31:0] e1_adr [14] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C,
                               32'h20, 32'h24, 32'h24, 32'h24, 32'h28, 32'h2C};
  logic [31:0] e1_dat [14] = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210,
                               32'h89ABCDEF, 32'h01234567, 32'h4E6F7720, 32'h69732074,
                               32'h00000001, 32'h0, 32'h0, 32'h1, 32'h3FA40E8A, 32'h984D4815};
  logic [31:0] e2_adr [6]  = '{32'h18, 32'h1C, 32'h20, 32'h24, 32'h28, 32'h2C};
  logic [31:0] e2_dat [6]  = '{32'h4E6F7720, 32'h69732074, 32'h00000003, 32'h1,
                               32'h3FA40E8A, 32'h984D4815};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int bad;
    int found;

    repeat (3) @(posedge clk);
    #1;
    rst_sys = 1'b0;
    check_eq("reset_outputs",
             {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o,
              bus.wbm_dat_o, job_ready, res_valid, res_data, res_err},
             {3'b000, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 64'h0, 2'b00});

    // Job 1: cold cache, STATUS 0,0,1
    start_job(K1, D1, 1'b0, 2);
    wait_result(lat);
    check_eq("j1_count", n_xfer - start_n, 14);
    for (int i = 0; i < 14; i++) check_xfer("j1_xfer", i, e1_adr[i], i < 9, e1_dat[i]);
    check_eq("j1_res", {res_data, res_err}, {R1, 2'b00});

    // Result held while consumer stalls; job offers ignored; bus quiet
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      job_valid = c[0];
      job_key   = K2;
      @(posedge clk);
      #1;
      if (!(res_valid && res_data == R1 && res_err == 2'b00 && !job_ready &&
            !bus.wbm_cyc_o && !bus.wbm_stb_o && n_xfer == start_n + 14)) bad++;
    end
    job_valid = 1'b0;
    check_eq("done_hold", bad, 0);
    take_result();
    check_eq("ready_after_take", {job_ready, res_valid}, 2'b10);

    // Job 2: cache hit, decrypt, done on first poll
    start_job(K1, D1, 1'b1, 0);
    wait_result(lat);
    check_eq("j2_latency", lat, 15);
    check_eq("j2_count", n_xfer - start_n, 6);
    for (int i = 0; i < 6; i++) check_xfer("j2_xfer", i, e2_adr[i], i < 3, e2_dat[i]);
    check_eq("j2_res", {res_data, res_err}, {R1, 2'b00});
    take_result();

    // Job 3: STATUS never done -> exactly MAX_POLLS (4) reads then timeout
    start_job(K1, D1, 1'b0, 1000);
    wait_result(lat);
    check_eq("j3_polls", poll_total - poll_base, 4);
    check_eq("j3_count", n_xfer - start_n, 7);
    check_eq("j3_res", {res_valid, res_data, res_err}, {1'b1, 64'h0, 2'b10});
    take_result();

    // Job 4: bus error on KEY2 write
    err_en  = 1'b1;
    err_adr = 32'h08;
    start_job(K2, D1, 1'b0, 0);
    wait_result(lat);
    check_eq("j4_count", n_xfer - start_n, 3);
    check_xfer("j4_err_xfer", 2, 32'h08, 1'b1, 32'h8899AABB);
    check_eq("j4_bus_idle", {bus.wbm_cyc_o, bus.wbm_stb_o}, 2'b00);
    check_eq("j4_res", {res_data, res_err}, {64'h0, 2'b01});
    take_result();
    err_en = 1'b0;

    // Job 5: K1 was cached before the error, but the error invalidated the cache
    start_job(K1, D1, 1'b0, 0);
    wait_result(lat);
    check_eq("j5_count", n_xfer - start_n, 12);
    check_xfer("j5_first", 0, 32'h00, 1'b1, 32'h01234567);
    check_eq("j5_res", {res_data, res_err}, {R1, 2'b00});
    take_result();

    // Job 6: reset while a STATUS read strobe is out
    start_job(K1, D1, 1'b0, 1000);
    found = 0;
    for (int c = 0; c < 60 && found == 0; c++) begin
      @(posedge clk);
      #1;
      if (bus.wbm_stb_o && bus.wbm_adr_o == 32'h24) found = 1;
    end
    check_eq("j6_poll_seen", found, 1);
    rst_sys = 1'b1;
    @(posedge clk);
    #1;
    check_eq("j6_reset_outputs",
             {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o,
              bus.wbm_dat_o, job_ready, res_valid, res_data, res_err},
             {3'b000, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 64'h0, 2'b00});
    rst_sys = 1'b0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (res_valid || bus.wbm_stb_o) bad++;
    end
    check_eq("j6_no_result", bad, 0);

    // Job 7: cache cleared by reset, key rewritten from 0x00
    start_job(K1, D1, 1'b0, 0);
    wait_result(lat);
    check_eq("j7_count", n_xfer - start_n, 12);
    check_xfer("j7_first", 0, 32'h00, 1'b1, 32'h01234567);
    check_eq("j7_res", {res_data, res_err}, {R1, 2'b00});
    take_result();

    check_eq("bus_protocol", proto_bad, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
